// File: rtl/la_trigger.sv
`default_nettype none
// ============================================================================
// Module   : la_trigger
// Brief    : Masked level/edge trigger that gates a post-trigger window of
//            probe samples into the logic analyzer.
// Revision : 1.0
// ============================================================================
module la_trigger #(
    parameter int pLA_WIDTH  = 24,
    parameter int pCNT_WIDTH = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic [pLA_WIDTH-1:0]  la_probe,
    input  logic                  trig_arm,
    input  logic                  trig_abort,
    input  logic [pLA_WIDTH-1:0]  trig_mask,
    input  logic [pLA_WIDTH-1:0]  trig_value,
    input  logic [pLA_WIDTH-1:0]  trig_edge,
    input  logic [7:0]            trig_match_cnt,
    input  logic [pCNT_WIDTH-1:0] post_len,
    output logic [pLA_WIDTH-1:0]  up_la_data,
    output logic                  la_gate,
    output logic                  trig_fired,
    output logic                  capture_done,
    output logic [1:0]            trig_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [pLA_WIDTH-1:0]    s1_q, s2_q;
    logic [7:0]              run_q, run_d;
    logic [pCNT_WIDTH-1:0]   post_cnt_q, post_cnt_d;
    logic                    fired_q, fired_d;

    logic [pLA_WIDTH-1:0]    w_bit_ok;
    logic                    w_hit;
    logic [7:0]              w_need;
    logic [8:0]              w_run_inc;
    logic                    w_met;

    // Edge bits additionally require the older sample to differ from the target.
    assign w_bit_ok  = ~trig_mask |
                       (~(s1_q ^ trig_value) & (~trig_edge | (s2_q ^ trig_value)));
    assign w_hit     = &w_bit_ok;
    assign w_need    = (trig_match_cnt == 8'd0) ? 8'd1 : trig_match_cnt;
    assign w_run_inc = {1'b0, run_q} + 9'd1;
    assign w_met     = (w_run_inc >= {1'b0, w_need});

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        post_cnt_d = post_cnt_q;
        fired_d    = 1'b0;
        if (trig_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_arm) begin
                        state_d = ST_ARMED;
                        run_d   = 8'd0;
                    end
                end
                ST_ARMED: begin
                    if (w_hit) begin
                        run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
                        if (w_met) begin
                            state_d    = ST_CAPTURE;
                            fired_d    = 1'b1;
                            post_cnt_d = post_len;
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                end
                ST_CAPTURE: begin
                    // A zero count means an unbounded window: it never reaches 1.
                    if (post_cnt_q == {{(pCNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end else if (post_cnt_q != '0) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (trig_arm) begin
                        state_d = ST_ARMED;
                        run_d   = 8'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= ST_IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            run_q      <= 8'd0;
            post_cnt_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= la_probe;
            s2_q       <= s1_q;
            run_q      <= run_d;
            post_cnt_q <= post_cnt_d;
            fired_q    <= fired_d;
        end
    end

    assign la_gate      = (state_q == ST_CAPTURE);
    assign up_la_data   = la_gate ? s2_q : '0;
    assign trig_fired   = fired_q;
    assign capture_done = (state_q == ST_DONE);
    assign trig_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_la_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_trigger
// Brief    : Self-checking bench for la_trigger against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_la_trigger;
    localparam int W  = 24;
    localparam int CW = 16;

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic [W-1:0]  la_probe = '0, trig_mask = '0, trig_value = '0, trig_edge = '0;
    logic          trig_arm = 1'b0, trig_abort = 1'b0;
    logic [7:0]    trig_match_cnt = 8'd0;
    logic [CW-1:0] post_len = '0;
    logic [W-1:0]  up_la_data;
    logic          la_gate, trig_fired, capture_done;
    logic [1:0]    trig_state;

    la_trigger #(.pLA_WIDTH(W), .pCNT_WIDTH(CW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .la_probe(la_probe),
        .trig_arm(trig_arm), .trig_abort(trig_abort), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_edge(trig_edge),
        .trig_match_cnt(trig_match_cnt), .post_len(post_len),
        .up_la_data(up_la_data), .la_gate(la_gate), .trig_fired(trig_fired),
        .capture_done(capture_done), .trig_state(trig_state)
    );

    always #5 axi_clk = ~axi_clk;

    int n_vec = 0, n_err = 0;
    int m_state = 0, m_run = 0, m_capcyc = 0;
    bit m_fired = 1'b0;
    logic [W-1:0] m_s1 = '0, m_s2 = '0;
    int obs_fired = 0, obs_gate = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        for (int i = 0; i < W; i++) begin
            if (trig_mask[i]) begin
                if (m_s1[i] != trig_value[i]) return 1'b0;
                if (trig_edge[i] && (m_s2[i] == trig_value[i])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_capcyc = 0; m_fired = 1'b0; m_s1 = '0; m_s2 = '0;
    endtask

    // One clock of the reference behaviour, using the inputs present before the edge.
    task automatic model_step();
        int need;
        bit hit;
        if (axi_reset) begin
            model_reset();
            return;
        end
        hit     = model_hit();
        need    = (trig_match_cnt == 0) ? 1 : int'(trig_match_cnt);
        m_fired = 1'b0;
        if (trig_abort) m_state = 0;
        else case (m_state)
            0: if (trig_arm) begin m_state = 1; m_run = 0; end
            1: if (hit) begin
                   m_run++;
                   if (m_run >= need) begin m_state = 2; m_fired = 1'b1; m_capcyc = 0; end
               end else m_run = 0;
            2: begin
                   m_capcyc++;
                   if (post_len != 0 && m_capcyc == int'(post_len)) m_state = 3;
               end
            default: if (trig_arm) begin m_state = 1; m_run = 0; end
        endcase
        m_s2 = m_s1;
        m_s1 = la_probe;
    endtask

    task automatic tick();
        @(negedge axi_clk);
        check("state", {30'd0, trig_state}, m_state);
        check("gate", {31'd0, la_gate}, (m_state == 2) ? 1 : 0);
        check("data", {8'd0, up_la_data}, (m_state == 2) ? {8'd0, m_s2} : 32'd0);
        check("fired", {31'd0, trig_fired}, {31'd0, m_fired});
        check("done", {31'd0, capture_done}, (m_state == 3) ? 1 : 0);
        if (la_gate) obs_gate++;
        if (trig_fired) obs_fired++;
        @(posedge axi_clk);
        model_step();
        #1;
    endtask

    task automatic cfg(input logic [W-1:0] m, input logic [W-1:0] v, input logic [W-1:0] e,
                       input logic [7:0] c, input logic [CW-1:0] p);
        trig_mask = m; trig_value = v; trig_edge = e; trig_match_cnt = c; post_len = p;
    endtask

    task automatic pulse_arm();
        trig_arm = 1'b1; tick(); trig_arm = 1'b0;
    endtask

    task automatic pulse_abort();
        trig_abort = 1'b1; tick(); trig_abort = 1'b0;
    endtask

    task automatic clr_obs();
        obs_fired = 0; obs_gate = 0;
    endtask

    initial begin
        logic [5:0] pat;
        #2;
        check("rst_state", {30'd0, trig_state}, 0);
        check("rst_gate", {31'd0, la_gate}, 0);
        check("rst_data", {8'd0, up_la_data}, 0);
        check("rst_fired", {31'd0, trig_fired}, 0);
        check("rst_done", {31'd0, capture_done}, 0);
        tick(); tick();
        axi_reset = 1'b0;
        tick();

        // Level trigger, 4-cycle window
        cfg(24'h1, 24'h1, 24'h0, 8'd1, 16'd4);
        pulse_arm(); tick(); clr_obs();
        la_probe = 24'h1;
        repeat (8) tick();
        check("t1_fired_cnt", obs_fired, 1);
        check("t1_gate_len", obs_gate, 4);
        check("t1_done", {30'd0, trig_state}, 3);
        la_probe = '0; pulse_abort();

        // Edge trigger: a held level must not fire
        cfg(24'h100, 24'h100, 24'h100, 8'd1, 16'd3);
        la_probe = 24'h100; repeat (3) tick();
        clr_obs(); pulse_arm(); repeat (5) tick();
        check("t2_no_fire", obs_fired, 0);
        la_probe = '0; tick();
        la_probe = 24'h100; repeat (8) tick();
        check("t2_fire_once", obs_fired, 1);
        la_probe = '0; pulse_abort();

        // Three consecutive matches required
        cfg(24'h1, 24'h1, 24'h0, 8'd3, 16'd2);
        pulse_arm(); clr_obs();
        pat = 6'b111011;
        for (int i = 5; i >= 0; i--) begin la_probe = {23'd0, pat[i]}; tick(); end
        la_probe = '0;
        repeat (6) tick();
        check("t3_fire_once", obs_fired, 1);
        pulse_abort();

        // Unbounded window then abort
        cfg(24'h0, 24'h0, 24'h0, 8'd0, 16'd0);
        clr_obs(); pulse_arm();
        repeat (1002) begin la_probe = W'($urandom); tick(); end
        check("t4_gate_long", (obs_gate >= 1000) ? 1 : 0, 1);
        pulse_abort(); tick();
        check("t4_idle", {30'd0, trig_state}, 0);

        // Abort+arm in DONE, arm during CAPTURE ignored
        cfg(24'h1, 24'h1, 24'h0, 8'd1, 16'd5);
        la_probe = 24'h1; pulse_arm();
        for (int i = 0; i < 20 && m_state != 3; i++) tick();
        trig_arm = 1'b1; trig_abort = 1'b1; tick(); trig_arm = 1'b0; trig_abort = 1'b0;
        check("t5_abort_prio", {30'd0, trig_state}, 0);
        clr_obs(); pulse_arm();
        for (int i = 0; i < 10 && !la_gate; i++) tick();
        pulse_arm();
        for (int i = 0; i < 20 && m_state != 3; i++) tick();
        check("t5_win_len", obs_gate, 5);
        check("t5_fired", obs_fired, 1);
        la_probe = '0; pulse_abort();

        // Asynchronous reset during capture
        cfg(24'h0, 24'h0, 24'h0, 8'd1, 16'd20);
        la_probe = 24'hABCDEF; pulse_arm(); repeat (4) tick();
        check("t6_in_capture", {30'd0, trig_state}, 2);
        #2 axi_reset = 1'b1; #1;
        check("t6_state", {30'd0, trig_state}, 0);
        check("t6_gate", {31'd0, la_gate}, 0);
        check("t6_data", {8'd0, up_la_data}, 0);
        check("t6_fired", {31'd0, trig_fired}, 0);
        check("t6_done", {31'd0, capture_done}, 0);
        model_reset();
        tick(); tick();
        axi_reset = 1'b0;
        repeat (4) tick();
        check("t6_stays_idle", {30'd0, trig_state}, 0);

        // Randomized scenarios
        repeat (60) begin
            logic [W-1:0] m;
            pulse_abort();
            case ($urandom % 4)
                0: m = '0;
                1: m = W'(1) << ($urandom % W);
                default: m = (W'(1) << ($urandom % W)) | (W'(1) << ($urandom % W));
            endcase
            cfg(m, W'($urandom), W'($urandom) & m, 8'($urandom % 4), CW'($urandom % 9));
            pulse_arm();
            repeat (40) begin
                la_probe   = W'($urandom);
                trig_arm   = ($urandom % 20) == 0;
                trig_abort = ($urandom % 50) == 0;
                tick();
            end
            trig_arm = 1'b0; trig_abort = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
